// File: rtl/uart_matrix_loader.sv
// Parses ASCII hex words from the UART byte stream and writes them linearly into SRAM.
// Both operand matrices (2*SIZE*SIZE words) are filled before the multiplier runs.
module uart_matrix_loader #(
  parameter int SIZE       = 4,
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            rx_byte,
  input  logic                  received,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  // state   | meaning
  // S_IDLE  | after reset, bytes ignored until start
  // S_PARSE | consuming hex digits and separators
  // S_DONE  | all 2*SIZE*SIZE words written
  // S_ERR   | bad byte, too many digits or overflow; halted until start
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PARSE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam int ACC_W  = MAX_DIGITS * 4;
  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
  localparam int TOTAL  = 2 * SIZE * SIZE;

  logic [1:0]            state;
  logic [ACC_W-1:0]      acc;
  logic [NDIG_W-1:0]     ndig;
  logic                  is_hex;
  logic                  is_sep;
  logic [3:0]            nibble;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] acc_word;

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end
  end

  assign is_sep = (rx_byte == 8'h20) || (rx_byte == 8'h2C) || (rx_byte == 8'h0D) ||
                  (rx_byte == 8'h0A) || (rx_byte == 8'h5B) || (rx_byte == 8'h5D);

  // Accumulator may be wider or narrower than the SRAM word depending on parameters.
  generate
    if (ACC_W > DATA_WIDTH) begin : g_wide_acc
      assign overflow = |acc[ACC_W-1:DATA_WIDTH];
      assign acc_word = acc[DATA_WIDTH-1:0];
    end else begin : g_narrow_acc
      assign overflow = 1'b0;
      assign acc_word = DATA_WIDTH'(acc);
    end
  endgenerate

  assign busy = (state == S_PARSE);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      acc          <= '0;
      ndig         <= '0;
      words_loaded <= '0;
      sram_we      <= 1'b0;
      sram_addr    <= '0;
      sram_data    <= '0;
    end else begin
      sram_we <= 1'b0;
      // start has priority over a coincident byte, which is dropped
      if (start) begin
        state        <= S_PARSE;
        acc          <= '0;
        ndig         <= '0;
        words_loaded <= '0;
      end else if (state == S_PARSE && received) begin
        if (is_hex) begin
          if (ndig == NDIG_W'(MAX_DIGITS)) begin
            state <= S_ERR;
          end else begin
            acc  <= {acc[ACC_W-5:0], nibble};
            ndig <= ndig + NDIG_W'(1);
          end
        end else if (is_sep) begin
          if (ndig != '0) begin
            if (overflow) begin
              state <= S_ERR;
            end else begin
              sram_we      <= 1'b1;
              sram_addr    <= ADDR_WIDTH'(BASE_ADDR) + words_loaded;
              sram_data    <= acc_word;
              words_loaded <= words_loaded + ADDR_WIDTH'(1);
              acc          <= '0;
              ndig         <= '0;
              if (words_loaded == ADDR_WIDTH'(TOTAL - 1))
                state <= S_DONE;
            end
          end
        end else begin
          state <= S_ERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Directed bench for uart_matrix_loader: drives ASCII byte streams and checks the
// SRAM write log and status flags against hand-computed values.
module tb_uart_matrix_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        received = 1'b0;
  logic        sram_we;
  logic [10:0] sram_addr;
  logic [17:0] sram_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;

  int n_chk = 0;
  int n_bad = 0;

  logic [10:0] wr_addr[$];
  logic [17:0] wr_data[$];
  logic        wr_done[$];

  uart_matrix_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .rx_byte      (rx_byte),
    .received     (received),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_data    (sram_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sram_we) begin
      wr_addr.push_back(sram_addr);
      wr_data.push_back(sram_data);
      wr_done.push_back(done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_done.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    string s;

    // reset held, then released without start: bytes ignored
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wl", words_loaded, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_data", sram_data, 0);
    reset_n = 1'b1;
    send_str("12 ");
    chk("idle_writes", wr_addr.size(), 0);
    chk("idle_busy", busy, 0);
    chk("idle_wl", words_loaded, 0);

    // full load of 32 words, values 1..0x20
    pulse_start();
    chk("arm_busy", busy, 1);
    s = "";
    for (int i = 1; i <= 32; i++) s = {s, $sformatf("%0h ", i)};
    send_str(s);
    chk("full_writes", wr_addr.size(), 32);
    if (wr_addr.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        chk($sformatf("full_addr%0d", i), wr_addr[i], i);
        chk($sformatf("full_data%0d", i), wr_data[i], i + 1);
        chk($sformatf("full_done%0d", i), wr_done[i], (i == 31) ? 1 : 0);
      end
    end
    chk("full_done", done, 1);
    chk("full_busy", busy, 0);
    chk("full_err", err, 0);
    chk("full_wl", words_loaded, 32);
    send_str("7 ");
    chk("done_ignores", wr_addr.size(), 32);

    // max value, lowercase digit, CR/LF separators
    clear_log();
    pulse_start();
    chk("reload_done", done, 0);
    send_str("3FFFF,0a\r\n");
    chk("mix_writes", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("mix_addr0", wr_addr[0], 0);
      chk("mix_data0", wr_data[0], 18'h3FFFF);
      chk("mix_addr1", wr_addr[1], 1);
      chk("mix_data1", wr_data[1], 18'h0000A);
    end
    chk("mix_busy", busy, 1);
    chk("mix_wl", words_loaded, 2);

    // overflow
    clear_log();
    pulse_start();
    send_str("40000 ");
    chk("ovf_writes", wr_addr.size(), 0);
    chk("ovf_err", err, 1);
    chk("ovf_busy", busy, 0);
    chk("ovf_done", done, 0);

    // too many digits: fine after 5, error on the 6th
    pulse_start();
    chk("dig_err_clr", err, 0);
    send_str("12345");
    chk("dig5_err", err, 0);
    send_str("6");
    chk("dig6_err", err, 1);

    // illegal character
    pulse_start();
    send_str("1");
    chk("bad1_err", err, 0);
    send_str("G");
    chk("badG_err", err, 1);
    send_str("5 ");
    chk("err_ignores", wr_addr.size(), 0);
    pulse_start();
    chk("rearm_err", err, 0);
    chk("rearm_busy", busy, 1);
    chk("rearm_wl", words_loaded, 0);

    // restart mid-word discards the partial "7"
    send_str("5 7");
    chk("pre_restart_wl", words_loaded, 1);
    clear_log();
    pulse_start();
    chk("restart_wl", words_loaded, 0);
    send_str("9 ");
    chk("restart_writes", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("restart_addr", wr_addr[0], 0);
      chk("restart_data", wr_data[0], 9);
    end
    chk("restart_wl1", words_loaded, 1);

    // start coincident with a byte: byte is dropped
    clear_log();
    @(negedge clk);
    start = 1'b1; rx_byte = 8'h20; received = 1'b1;
    @(negedge clk);
    start = 1'b0; received = 1'b0;
    @(negedge clk);
    send_str("4 ");
    chk("coinc_writes", wr_addr.size(), 1);
    if (wr_addr.size() == 1) chk("coinc_data", wr_data[0], 4);

    // asynchronous reset mid-load after 10 words
    clear_log();
    pulse_start();
    send_str("1 2 3 4 5 6 7 8 9 A ");
    chk("pre_rst_wl", words_loaded, 10);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wl", words_loaded, 0);
    chk("arst_addr", sram_addr, 0);
    chk("arst_data", sram_data, 0);
    chk("arst_we", sram_we, 0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    send_str("12 ");
    chk("post_rst_writes", wr_addr.size(), 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_wl", words_loaded, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
